tc_rom_loader: RTL and testbench
================================

Name: tc_rom_loader

Overview:
Bus initiator that fills a TC_Rom-style word memory from a byte stream, driving its load/save/address/in ports and consuming its out port. It packs incoming bytes little-endian into BIT_WIDTH words and writes them at auto-incrementing addresses. After the last byte it reads every written word back and compares an XOR checksum. It sits between a host/UART byte source and the program ROM for boot-time image loading.

Parameters:
BIT_WIDTH, 16, ROM word width; multiple of 8, 8..64.
MEM_WORDS, 256, ROM depth in words; writes at addresses >= MEM_WORDS are suppressed.
BYTES (localparam), BIT_WIDTH/8, bytes per word.

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous active-low reset
start  input  1  begin a load session (IDLE or DONE only)
in_valid  input  1  byte stream valid
in_ready  output  1  byte accepted when in_valid & in_ready
in_data  input  8  stream byte
in_last  input  1  marks final byte of image
rom_load  output  1  ROM read strobe
rom_save  output  1  ROM write strobe
rom_address  output  16  ROM word address
rom_in  output  BIT_WIDTH  ROM write data
rom_out  input  BIT_WIDTH  ROM read data (Z when not loading)
busy  output  1  session in progress
done  output  1  level; session finished
error  output  2  [0] readback mismatch, [1] overflow; valid when done=1
word_count  output  16  words written (saves issued)

Behaviour:
- Reset (rst=0 at posedge): state IDLE; all outputs 0; byte lane index, addresses, checksums, word register cleared. Mid-session reset abandons the session; no rom_save/rom_load is asserted in the cycle after reset.
- States: IDLE, RECV, WRITE, RD_REQ, RD_CHK, DONE.
- IDLE/DONE: in_ready=0. start=1 -> RECV; clears waddr, raddr, word_count, checksums, error, done; busy=1. start is ignored in any other state.
- RECV: in_ready=1. Accepted byte goes to lane idx (byte idx occupies bits 8*idx+7:8*idx); idx++. When idx==BYTES-1 or in_last -> WRITE, latching last_seen=in_last. Unfilled high lanes are zero. No acceptance when in_valid=0; gaps are allowed.
- WRITE (1 cycle, in_ready=0): if waddr<MEM_WORDS: rom_save=1, rom_address=waddr, rom_in=word, wsum^=word, waddr++, word_count++. Otherwise no save and error[1]=1. Clear word register and idx. Next state: RD_REQ if last_seen, else RECV.
- Overflow: bytes after capacity are still accepted and dropped until in_last, which drains the source.
- RD_REQ: if raddr==word_count, compare: error[0]=(rsum!=wsum), then DONE. Otherwise rom_load=1, rom_address=raddr -> RD_CHK.
- RD_CHK: rom_load=0. Sample rom_out, which is valid the cycle after the load posedge. rsum^=rom_out, raddr++ -> RD_REQ. Each word takes 2 cycles.
- DONE: busy=0, done=1; error and word_count held until next start or reset.
- rom_out is never sampled outside RD_CHK.
- Strobes are single-cycle; rom_address/rom_in are 0 when no strobe is active.
- Empty image: not representable, because in_last always carries a byte. A 1-byte image writes one padded word.
- Address arithmetic is 16-bit unsigned; MEM_WORDS <= 65536.

Decomposition:
- Shared package tc_rom_pkg: state enum type, ERR_MISMATCH=0 and ERR_OVERFLOW=1 bit indices, and a function computing BYTES from BIT_WIDTH.
- One natural sub-module, tc_byte_packer: the byte lane index and word register, with clear, accept, and full/last outputs.
- FSM and readback checksum stay in tc_rom_loader.

Test Plan:
1. BIT_WIDTH=16, MEM_WORDS=256 with TC_Rom model. Stream 0x34,0x12,0x78,0x56 (last on 4th) -> saves at addr 0 = 0x1234 and addr 1 = 0x5678; two loads at 0 and 1; done=1, error=00, word_count=2.
2. Stream 0xAA,0xBB,0xCC (last on 3rd) -> addr 0 = 0xBBAA, addr 1 = 0x00CC; error=00.
3. MEM_WORDS=4, 10 bytes -> exactly 4 saves (addr 0..3); 5th WRITE suppressed; all 10 bytes accepted; error[1]=1, word_count=4, readback of 4 words gives error[0]=0.
4. ROM model corrupts addr 1 to 0xFFFF after write (case 1 image) -> error[0]=1, done=1.
5. Reset held low mid-RECV after 1 byte -> all outputs 0, state IDLE. A new start plus 2 bytes 0x01,0x02 (last) -> addr 0 = 0x0201, word_count=1.
6. in_valid toggling every other cycle plus start pulses while busy -> start ignored, image identical to case 1, no extra saves.

Source files
------------

// File: rtl/tc_rom_pkg.sv
// ---------------------------------------------------------------------------
// tc_rom_pkg
// Shared definitions for the TC_Rom boot loader.
//   state_e         : loader FSM states
//   ERR_MISMATCH    : bit index of the readback-checksum error flag
//   ERR_OVERFLOW    : bit index of the image-too-large error flag
//   bytes_per_word  : number of byte lanes in a ROM word
// ---------------------------------------------------------------------------
package tc_rom_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RECV   = 3'd1,
      ST_WRITE  = 3'd2,
      ST_RD_REQ = 3'd3,
      ST_RD_CHK = 3'd4,
      ST_DONE   = 3'd5
   } state_e;

   localparam int ERR_MISMATCH = 0;
   localparam int ERR_OVERFLOW = 1;

   function automatic int bytes_per_word(input int bit_width);
      return bit_width / 8;
   endfunction

endpackage

// File: rtl/tc_byte_packer.sv
// ---------------------------------------------------------------------------
// tc_byte_packer
// Packs a byte stream little-endian into BIT_WIDTH words.
//   clk, rst   : clock, synchronous active-low reset
//   clear_i    : empty the word register and return to lane 0 (wins over accept)
//   accept_i   : byte_i is taken into the current lane
//   byte_i     : incoming byte
//   word_o     : current word with byte_i merged into the current lane, so the
//                consumer can capture a completed word on the accepting edge
//   full_o     : current lane is the last lane of the word
// ---------------------------------------------------------------------------
module tc_byte_packer
   import tc_rom_pkg::*;
#(
   parameter int BIT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear_i,
   input  logic                 accept_i,
   input  logic [7:0]           byte_i,
   output logic [BIT_WIDTH-1:0] word_o,
   output logic                 full_o
);

   localparam int BYTES = bytes_per_word(BIT_WIDTH);
   localparam int IDXW  = (BYTES > 1) ? $clog2(BYTES) : 1;

   logic [IDXW-1:0]      idx_q, idx_d;
   logic [BIT_WIDTH-1:0] word_q, word_d;
   logic [BIT_WIDTH-1:0] merged_s;

   // Merge the incoming byte into its lane and compute next lane/word state.
   always_comb begin
      merged_s = word_q;
      merged_s[{idx_q, 3'b000} +: 8] = byte_i;
      if (clear_i) begin
         idx_d  = '0;
         word_d = '0;
      end else if (accept_i) begin
         idx_d  = idx_q + {{(IDXW-1){1'b0}}, 1'b1};
         word_d = merged_s;
      end else begin
         idx_d  = idx_q;
         word_d = word_q;
      end
   end

   // Lane index and partial word registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         idx_q  <= '0;
         word_q <= '0;
      end else begin
         idx_q  <= idx_d;
         word_q <= word_d;
      end
   end

   assign word_o = merged_s;
   assign full_o = (idx_q == IDXW'(BYTES - 1));

endmodule

// File: rtl/tc_rom_loader.sv
// ---------------------------------------------------------------------------
// tc_rom_loader
// Boot-time loader: fills a TC_Rom-style memory from a byte stream, then
// reads every written word back and compares XOR checksums.
//   clk, rst                 : clock, synchronous active-low reset
//   start                    : begin a session (honoured in IDLE/DONE only)
//   in_valid/in_ready        : byte stream handshake
//   in_data, in_last         : stream byte, final-byte marker
//   rom_load/rom_save        : single-cycle ROM read/write strobes
//   rom_address, rom_in      : ROM address / write data, zero when idle
//   rom_out                  : ROM read data, valid the cycle after a load
//   busy, done               : session in progress / finished (level)
//   error                    : [0] readback mismatch, [1] overflow
//   word_count               : number of words actually saved
// ---------------------------------------------------------------------------
module tc_rom_loader
   import tc_rom_pkg::*;
#(
   parameter int BIT_WIDTH = 16,
   parameter int MEM_WORDS = 256
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [7:0]           in_data,
   input  logic                 in_last,
   output logic                 rom_load,
   output logic                 rom_save,
   output logic [15:0]          rom_address,
   output logic [BIT_WIDTH-1:0] rom_in,
   input  logic [BIT_WIDTH-1:0] rom_out,
   output logic                 busy,
   output logic                 done,
   output logic [1:0]           error,
   output logic [15:0]          word_count
);

   state_e               state_q;
   logic [15:0]          waddr_q, raddr_q, word_count_q, rom_address_q;
   logic [BIT_WIDTH-1:0] wsum_q, rsum_q, rom_in_q;
   logic                 last_seen_q, in_ready_q, rom_load_q, rom_save_q;
   logic                 busy_q, done_q;
   logic [1:0]           error_q;

   logic                 accept_s, word_end_s, full_s, pk_clear_s, wr_ok_s;
   logic [BIT_WIDTH-1:0] pk_word_s;
   logic [15:0]          raddr_nxt_s;

   assign accept_s    = (state_q == ST_RECV) & in_ready_q & in_valid;
   assign word_end_s  = accept_s & (full_s | in_last);
   assign pk_clear_s  = word_end_s | (start & ((state_q == ST_IDLE) | (state_q == ST_DONE)));
   assign wr_ok_s     = ({16'd0, waddr_q} < 32'(MEM_WORDS));
   assign raddr_nxt_s = raddr_q + 16'd1;

   tc_byte_packer #(.BIT_WIDTH(BIT_WIDTH)) u_packer (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (pk_clear_s),
      .accept_i (accept_s),
      .byte_i   (in_data),
      .word_o   (pk_word_s),
      .full_o   (full_s)
   );

   // Loader FSM. Outputs are registered, so each strobe is decided on the
   // edge that enters the state in which it is visible: the save is issued
   // on the edge that completes a word (visible during WRITE), and the load
   // for a word is issued on the edge that enters RD_REQ (so rom_load_q
   // doubles as "more words to read back" while in RD_REQ).
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         waddr_q       <= '0;
         raddr_q       <= '0;
         word_count_q  <= '0;
         wsum_q        <= '0;
         rsum_q        <= '0;
         last_seen_q   <= 1'b0;
         in_ready_q    <= 1'b0;
         rom_load_q    <= 1'b0;
         rom_save_q    <= 1'b0;
         rom_address_q <= '0;
         rom_in_q      <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         error_q       <= '0;
      end else begin
         rom_load_q    <= 1'b0;
         rom_save_q    <= 1'b0;
         rom_address_q <= '0;
         rom_in_q      <= '0;
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_q      <= ST_RECV;
                  waddr_q      <= '0;
                  raddr_q      <= '0;
                  word_count_q <= '0;
                  wsum_q       <= '0;
                  rsum_q       <= '0;
                  last_seen_q  <= 1'b0;
                  error_q      <= '0;
                  done_q       <= 1'b0;
                  busy_q       <= 1'b1;
                  in_ready_q   <= 1'b1;
               end
            end
            ST_RECV: begin
               if (word_end_s) begin
                  state_q     <= ST_WRITE;
                  in_ready_q  <= 1'b0;
                  last_seen_q <= in_last;
                  if (wr_ok_s) begin
                     rom_save_q    <= 1'b1;
                     rom_address_q <= waddr_q;
                     rom_in_q      <= pk_word_s;
                     wsum_q        <= wsum_q ^ pk_word_s;
                     waddr_q       <= waddr_q + 16'd1;
                     word_count_q  <= word_count_q + 16'd1;
                  end else begin
                     // Words beyond capacity are dropped; bytes keep flowing to drain the source.
                     error_q[ERR_OVERFLOW] <= 1'b1;
                  end
               end
            end
            ST_WRITE: begin
               if (last_seen_q) begin
                  state_q <= ST_RD_REQ;
                  if (raddr_q != word_count_q) begin
                     rom_load_q    <= 1'b1;
                     rom_address_q <= raddr_q;
                  end
               end else begin
                  state_q    <= ST_RECV;
                  in_ready_q <= 1'b1;
               end
            end
            ST_RD_REQ: begin
               if (rom_load_q) begin
                  state_q <= ST_RD_CHK;
               end else begin
                  error_q[ERR_MISMATCH] <= (rsum_q != wsum_q);
                  state_q               <= ST_DONE;
                  busy_q                <= 1'b0;
                  done_q                <= 1'b1;
               end
            end
            ST_RD_CHK: begin
               rsum_q  <= rsum_q ^ rom_out;
               raddr_q <= raddr_nxt_s;
               state_q <= ST_RD_REQ;
               if (raddr_nxt_s != word_count_q) begin
                  rom_load_q    <= 1'b1;
                  rom_address_q <= raddr_nxt_s;
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               busy_q     <= 1'b0;
               done_q     <= 1'b0;
               in_ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign rom_load    = rom_load_q;
   assign rom_save    = rom_save_q;
   assign rom_address = rom_address_q;
   assign rom_in      = rom_in_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign error       = error_q;
   assign word_count  = word_count_q;

endmodule

// File: tb/tb_tc_rom_loader.sv
// ---------------------------------------------------------------------------
// tb_tc_rom_loader
// Two loaders (256-word and 4-word ROMs) share one byte stream; each has its
// own TC_Rom model. Expected saves, loads, error flags and word counts are
// derived from the image bytes by a simple arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_tc_rom_loader;

   localparam int BW = 16;
   localparam int BYTES = BW / 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic in_valid = 1'b0;
   logic [7:0] in_data = 8'd0;
   logic in_last = 1'b0;

   logic in_ready_a, rom_load_a, rom_save_a, busy_a, done_a;
   logic in_ready_b, rom_load_b, rom_save_b, busy_b, done_b;
   logic [15:0] rom_address_a, rom_address_b, word_count_a, word_count_b;
   logic [BW-1:0] rom_in_a, rom_in_b, rom_out_a, rom_out_b;
   logic [1:0] error_a, error_b;

   always #5 clk = ~clk;

   tc_rom_loader #(.BIT_WIDTH(BW), .MEM_WORDS(256)) u_dut_a (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_data(in_data), .in_last(in_last), .rom_load(rom_load_a), .rom_save(rom_save_a),
      .rom_address(rom_address_a), .rom_in(rom_in_a), .rom_out(rom_out_a),
      .busy(busy_a), .done(done_a), .error(error_a), .word_count(word_count_a));

   tc_rom_loader #(.BIT_WIDTH(BW), .MEM_WORDS(4)) u_dut_b (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_data(in_data), .in_last(in_last), .rom_load(rom_load_b), .rom_save(rom_save_b),
      .rom_address(rom_address_b), .rom_in(rom_in_b), .rom_out(rom_out_b),
      .busy(busy_b), .done(done_b), .error(error_b), .word_count(word_count_b));

   // per-DUT views
   logic [1:0]    save_v, load_v, done_v, busy_v;
   logic [15:0]   addr_v [2];
   logic [BW-1:0] din_v [2];
   logic [1:0]    err_v [2];
   logic [15:0]   wc_v [2];
   assign save_v = {rom_save_b, rom_save_a};
   assign load_v = {rom_load_b, rom_load_a};
   assign done_v = {done_b, done_a};
   assign busy_v = {busy_b, busy_a};
   assign addr_v[0] = rom_address_a;  assign addr_v[1] = rom_address_b;
   assign din_v[0]  = rom_in_a;       assign din_v[1]  = rom_in_b;
   assign err_v[0]  = error_a;        assign err_v[1]  = error_b;
   assign wc_v[0]   = word_count_a;   assign wc_v[1]   = word_count_b;

   // TC_Rom models: write on save, read data presented the cycle after load
   logic [BW-1:0] mem [2][0:255];
   logic [1:0]    rd_vld = 2'b00;
   logic [BW-1:0] rd_data [2];
   bit            corrupt_en = 1'b0;
   logic [15:0]   corrupt_addr = 16'd0;
   assign rom_out_a = rd_vld[0] ? rd_data[0] : {BW{1'bz}};
   assign rom_out_b = rd_vld[1] ? rd_data[1] : {BW{1'bz}};

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (save_v[d])
            mem[d][addr_v[d][7:0]] <= (corrupt_en && addr_v[d] == corrupt_addr) ? 16'hFFFF : din_v[d];
         rd_vld[d] <= load_v[d];
         if (load_v[d]) rd_data[d] <= mem[d][addr_v[d][7:0]];
      end
   end

   // bus monitor: logs every save/load and counts protocol violations
   logic [15:0]   sv_addr [2][0:1023];
   logic [BW-1:0] sv_data [2][0:1023];
   logic [15:0]   ld_addr [2][0:1023];
   int sv_cnt [2];
   int ld_cnt [2];
   int idle_bad = 0;
   int rdy_diff = 0;
   initial begin
      sv_cnt[0] = 0; sv_cnt[1] = 0; ld_cnt[0] = 0; ld_cnt[1] = 0;
   end

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (save_v[d]) begin
            if (sv_cnt[d] < 1024) begin
               sv_addr[d][sv_cnt[d]] = addr_v[d];
               sv_data[d][sv_cnt[d]] = din_v[d];
            end
            sv_cnt[d] = sv_cnt[d] + 1;
         end
         if (load_v[d]) begin
            if (ld_cnt[d] < 1024) ld_addr[d][ld_cnt[d]] = addr_v[d];
            ld_cnt[d] = ld_cnt[d] + 1;
         end
         if (save_v[d] && load_v[d]) idle_bad++;
         if (!save_v[d] && !load_v[d] && (addr_v[d] != 16'd0 || din_v[d] != 16'd0)) idle_bad++;
      end
      if (in_ready_a !== in_ready_b) rdy_diff++;
   end

   int total = 0;
   int bad = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   logic [7:0] img [0:63];
   int img_len;

   // reference model: expected outcome of a session for a ROM of mem_words
   task automatic check_result(input int d, input int mem_words, input int base_sv, input int base_ld);
      logic [63:0] words [0:63];
      int nw, saves, n_sv, n_ld;
      bit ovf, mism;
      nw = (img_len + BYTES - 1) / BYTES;
      for (int w = 0; w < nw; w++) begin
         words[w] = 64'd0;
         for (int j = 0; j < BYTES; j++)
            if (w * BYTES + j < img_len)
               words[w] = words[w] + (64'(img[w * BYTES + j]) << (8 * j));
      end
      saves = (nw < mem_words) ? nw : mem_words;
      ovf   = (nw > mem_words);
      mism  = corrupt_en && (int'(corrupt_addr) < saves) && (words[corrupt_addr] != 64'hFFFF);
      n_sv  = sv_cnt[d] - base_sv;
      n_ld  = ld_cnt[d] - base_ld;
      check_eq($sformatf("d%0d_save_count", d), 64'(n_sv), 64'(saves));
      for (int i = 0; i < n_sv && i < saves; i++) begin
         check_eq($sformatf("d%0d_save_addr[%0d]", d, i), 64'(sv_addr[d][base_sv + i]), 64'(i));
         check_eq($sformatf("d%0d_save_data[%0d]", d, i), 64'(sv_data[d][base_sv + i]), words[i]);
      end
      check_eq($sformatf("d%0d_load_count", d), 64'(n_ld), 64'(saves));
      for (int i = 0; i < n_ld && i < saves; i++)
         check_eq($sformatf("d%0d_load_addr[%0d]", d, i), 64'(ld_addr[d][base_ld + i]), 64'(i));
      check_eq($sformatf("d%0d_error", d), 64'(err_v[d]), 64'({ovf, mism}));
      check_eq($sformatf("d%0d_word_count", d), 64'(wc_v[d]), 64'(saves));
      check_eq($sformatf("d%0d_done", d), 64'(done_v[d]), 64'd1);
      check_eq($sformatf("d%0d_busy", d), 64'(busy_v[d]), 64'd0);
   endtask

   // one load session with the image in img[]; gap_pct = chance of an idle cycle
   task automatic run_session(input int gap_pct, input bit spam);
      int k, cyc, b_sv[2], b_ld[2];
      bit fire;
      b_sv[0] = sv_cnt[0]; b_sv[1] = sv_cnt[1];
      b_ld[0] = ld_cnt[0]; b_ld[1] = ld_cnt[1];
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      k = 0; cyc = 0; fire = 1'b0;
      while (cyc < 3000) begin
         if (fire) k++;
         fire = 1'b0;
         if (k >= img_len) break;
         in_valid = ($urandom_range(99) >= gap_pct);
         in_data  = img[k];
         in_last  = (k == img_len - 1);
         fire     = in_valid && in_ready_a;
         start    = spam && busy_a && busy_b && ($urandom_range(2) == 0);
         @(negedge clk); cyc++;
      end
      in_valid = 1'b0; in_last = 1'b0; in_data = 8'd0;
      check_eq("bytes_accepted", 64'(k), 64'(img_len));
      cyc = 0;
      while (!(done_a && done_b) && cyc < 500) begin
         start = spam && busy_a && busy_b && ($urandom_range(2) == 0);
         @(negedge clk); cyc++;
      end
      start = 1'b0;
      check_eq("done_in_time", 64'(done_a && done_b), 64'd1);
      check_result(0, 256, b_sv[0], b_ld[0]);
      check_result(1, 4, b_sv[1], b_ld[1]);
   endtask

   task automatic check_reset_state();
      check_eq("rst_a", {in_ready_a, rom_load_a, rom_save_a, rom_address_a, rom_in_a,
                         busy_a, done_a, error_a, word_count_a}, 64'd0);
      check_eq("rst_b", {in_ready_b, rom_load_b, rom_save_b, rom_address_b, rom_in_b,
                         busy_b, done_b, error_b, word_count_b}, 64'd0);
   endtask

   initial begin
      int k;
      repeat (3) @(negedge clk);
      check_reset_state();
      rst = 1'b1;
      @(negedge clk);

      // case 1
      img[0] = 8'h34; img[1] = 8'h12; img[2] = 8'h78; img[3] = 8'h56; img_len = 4;
      run_session(0, 1'b0);
      // case 2
      img[0] = 8'hAA; img[1] = 8'hBB; img[2] = 8'hCC; img_len = 3;
      run_session(0, 1'b0);
      // case 3: overflows the 4-word ROM
      for (int i = 0; i < 10; i++) img[i] = 8'(8'h10 + 8'(i));
      img_len = 10;
      run_session(0, 1'b0);
      // case 4: corrupted word 1
      img[0] = 8'h34; img[1] = 8'h12; img[2] = 8'h78; img[3] = 8'h56; img_len = 4;
      corrupt_en = 1'b1; corrupt_addr = 16'd1;
      run_session(0, 1'b0);
      corrupt_en = 1'b0;
      // case 5: reset mid-receive after one byte
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 8'h55; in_last = 1'b0;
      @(negedge clk); in_valid = 1'b0; rst = 1'b0;
      @(negedge clk);
      check_reset_state();
      @(negedge clk);
      check_reset_state();
      rst = 1'b1;
      img[0] = 8'h01; img[1] = 8'h02; img_len = 2;
      run_session(0, 1'b0);
      // case 6: gappy stream and start pulses while busy
      img[0] = 8'h34; img[1] = 8'h12; img[2] = 8'h78; img[3] = 8'h56; img_len = 4;
      run_session(50, 1'b1);
      // 1-byte image
      img[0] = 8'h9C; img_len = 1;
      run_session(0, 1'b0);
      // randomized sessions
      for (int s = 0; s < 20; s++) begin
         img_len = $urandom_range(1, 12);
         for (int i = 0; i < img_len; i++) img[i] = 8'($urandom);
         corrupt_en   = ($urandom_range(3) == 0);
         corrupt_addr = 16'($urandom_range(0, 5));
         k = $urandom_range(0, 60);
         run_session(k, 1'($urandom_range(1)));
      end
      corrupt_en = 1'b0;
      @(negedge clk);
      check_eq("idle_bus_zero", 64'(idle_bad), 64'd0);
      check_eq("ready_agree", 64'(rdy_diff), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
